// File: rtl/posit_special_ctrl_if.sv
// Handshake and datapath-facing signals of the posit special-case controller.
// master drives operands/flags/encoder status; slave is the controller itself.
interface posit_special_ctrl_if #(
    parameter int N     = 32,
    parameter int DEPTH = 5
);
    logic             in_valid;
    logic             in_ready;
    logic             zero_a;
    logic             nar_a;
    logic             zero_b;
    logic             nar_b;
    logic             exp_zero;
    logic             exp_nar;
    logic [N-1:0]     pipe_result;
    logic             stall;
    logic [DEPTH-1:0] stage_clr;
    logic             encoder_start;
    logic             encode_done;
    logic             out_valid;
    logic [N-1:0]     out_result;
    logic             err_timeout;
    logic [15:0]      spec_cnt;

    modport master (
        output in_valid, zero_a, nar_a, zero_b, nar_b,
        output exp_zero, exp_nar, pipe_result, encode_done,
        input  in_ready, stall, stage_clr, encoder_start,
        input  out_valid, out_result, err_timeout, spec_cnt
    );

    modport slave (
        input  in_valid, zero_a, nar_a, zero_b, nar_b,
        input  exp_zero, exp_nar, pipe_result, encode_done,
        output in_ready, stall, stage_clr, encoder_start,
        output out_valid, out_result, err_timeout, spec_cnt
    );
endinterface

// File: rtl/posit_special_ctrl.sv
// Special-case controller for the posit multiplier: tracks zero/NaR tags alongside
// the datapath and substitutes the exact special word after an encoder handshake.
module posit_special_ctrl #(
    parameter int N         = 32,
    parameter int DEPTH     = 5,
    parameter int EXP_STAGE = 1,
    parameter int TIMEOUT   = 15
) (
    input logic               clk,
    input logic               rst_n,
    posit_special_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int             LAST      = DEPTH - 1;
    localparam logic [7:0]     WAIT_LAST = 8'(TIMEOUT - 1);
    localparam logic [N-1:0]   NAR_WORD  = {1'b1, {(N-1){1'b0}}};

    state_t           state;
    state_t           state_nxt;

    logic [DEPTH-1:0] tag_valid;
    logic [DEPTH-1:0] tag_zero;
    logic [DEPTH-1:0] tag_nar;
    logic [DEPTH-1:0] nxt_valid;
    logic [DEPTH-1:0] nxt_zero;
    logic [DEPTH-1:0] nxt_nar;
    logic [DEPTH-1:0] special;

    logic [7:0]       wait_cnt;
    logic             timed_out;
    logic             err_timeout;
    logic [15:0]      spec_cnt;

    logic             head_special;
    logic             stall;
    logic             encoder_start;
    logic             out_valid;
    logic [N-1:0]     out_result;
    logic             timeout_hit;

    assign special      = tag_zero | tag_nar;
    assign head_special = tag_valid[LAST] & special[LAST];

    // Next tag contents when the pipeline advances; exp-adder flags merge on
    // the hop out of EXP_STAGE, with NaR overriding zero.
    always_comb begin
        nxt_valid = '0;
        nxt_zero  = '0;
        nxt_nar   = '0;
        nxt_valid[0] = bus.in_valid;
        nxt_nar[0]   = bus.nar_a | bus.nar_b;
        nxt_zero[0]  = (bus.zero_a | bus.zero_b) & ~nxt_nar[0];
        for (int unsigned s = 1; s < DEPTH; s++) begin
            nxt_valid[s] = tag_valid[s-1];
            nxt_zero[s]  = tag_zero[s-1];
            nxt_nar[s]   = tag_nar[s-1];
        end
        nxt_nar[EXP_STAGE+1]  = tag_nar[EXP_STAGE] | bus.exp_nar;
        nxt_zero[EXP_STAGE+1] = (tag_zero[EXP_STAGE] | bus.exp_zero) & ~nxt_nar[EXP_STAGE+1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_valid <= '0;
            tag_zero  <= '0;
            tag_nar   <= '0;
        end else if (!stall) begin
            tag_valid <= nxt_valid;
            tag_zero  <= nxt_zero;
            tag_nar   <= nxt_nar;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        stall         = 1'b0;
        encoder_start = 1'b0;
        out_valid     = 1'b0;
        out_result    = bus.pipe_result;
        timeout_hit   = 1'b0;
        case (state)
            IDLE: begin
                if (head_special) begin
                    stall     = 1'b1;
                    state_nxt = START;
                end else begin
                    out_valid = tag_valid[LAST];
                end
            end
            START: begin
                stall         = 1'b1;
                encoder_start = 1'b1;
                state_nxt     = WAIT;
            end
            WAIT: begin
                stall = 1'b1;
                if (bus.encode_done) begin
                    state_nxt = DONE;
                end else if (wait_cnt == WAIT_LAST) begin
                    timeout_hit = 1'b1;
                    state_nxt   = DONE;
                end
            end
            DONE: begin
                out_valid  = 1'b1;
                out_result = (tag_nar[LAST] | timed_out) ? NAR_WORD : '0;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // timed_out remembers this handshake's abort so DONE can emit NaR;
    // err_timeout is the sticky, reset-only copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt    <= '0;
            timed_out   <= 1'b0;
            err_timeout <= 1'b0;
            spec_cnt    <= '0;
        end else begin
            if (state == START) begin
                wait_cnt  <= '0;
                timed_out <= 1'b0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (timeout_hit) begin
                timed_out   <= 1'b1;
                err_timeout <= 1'b1;
            end
            if (state == DONE && spec_cnt != '1) begin
                spec_cnt <= spec_cnt + 16'd1;
            end
        end
    end

    assign bus.in_ready      = ~stall;
    assign bus.stall         = stall;
    assign bus.stage_clr     = tag_valid & special;
    assign bus.encoder_start = encoder_start;
    assign bus.out_valid     = out_valid;
    assign bus.out_result    = out_result;
    assign bus.err_timeout   = err_timeout;
    assign bus.spec_cnt      = spec_cnt;

endmodule

// File: tb/tb_posit_special_ctrl.sv
// Directed bench for posit_special_ctrl (N=32, DEPTH=5, EXP_STAGE=1, TIMEOUT=15).
module tb_posit_special_ctrl;

    localparam int          N       = 32;
    localparam int          DEPTH   = 5;
    localparam int          TIMEOUT = 15;
    localparam logic [31:0] NAR     = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors     = 0;
    int   miscompares = 0;
    int   exp_spec    = 0;

    always #5 clk = ~clk;

    posit_special_ctrl_if #(.N(N), .DEPTH(DEPTH)) bus ();

    posit_special_ctrl #(
        .N(N), .DEPTH(DEPTH), .EXP_STAGE(1), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    task automatic check_bit(input string tag, input logic obs, input logic exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
        end
    endtask

    task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.in_valid    = 1'b0;
        bus.zero_a      = 1'b0;
        bus.nar_a       = 1'b0;
        bus.zero_b      = 1'b0;
        bus.nar_b       = 1'b0;
        bus.exp_zero    = 1'b0;
        bus.exp_nar     = 1'b0;
        bus.encode_done = 1'b0;
        bus.pipe_result = '0;
    endtask

    // One special op accepted in cycle 0; exp flags while it sits in stage 1;
    // encode_done in WAIT cycle k (k<0: never). A stray done pulse at cycle 3 must be ignored.
    task automatic special_op(input string name, input logic za, input logic nb,
                              input logic ez, input logic en, input int k,
                              input logic [31:0] exp_res);
        int done_c;
        done_c = (k >= 0) ? 8 + k : 7 + TIMEOUT;
        for (int j = 0; j <= done_c + 1; j++) begin
            clear_inputs();
            bus.pipe_result = 32'h5A5A_0000 + 32'(j);
            if (j == 0) begin
                bus.in_valid = 1'b1;
                bus.zero_a   = za;
                bus.nar_b    = nb;
            end
            if (j == 2) begin
                bus.exp_zero = ez;
                bus.exp_nar  = en;
            end
            if (j == 3) bus.encode_done = 1'b1;
            if (k >= 0 && j == 7 + k) bus.encode_done = 1'b1;
            @(negedge clk);
            check_bit($sformatf("%s.stall@%0d", name, j), bus.stall, (j >= 5 && j < done_c));
            check_bit($sformatf("%s.start@%0d", name, j), bus.encoder_start, (j == 6));
            check_bit($sformatf("%s.out_valid@%0d", name, j), bus.out_valid, (j == done_c));
            if (j == done_c)
                check_word($sformatf("%s.out_result", name), bus.out_result, exp_res);
            if (j == 1)
                check_word($sformatf("%s.stage_clr@1", name), 32'(bus.stage_clr),
                           (za | nb) ? 32'h1 : 32'h0);
            if (j == 4)
                check_word($sformatf("%s.stage_clr@4", name), 32'(bus.stage_clr), 32'h8);
            if (j == done_c + 1) begin
                exp_spec++;
                check_word($sformatf("%s.spec_cnt", name), 32'(bus.spec_cnt), 32'(exp_spec));
            end
            next_cycle();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        next_cycle();

        // Reset state
        check_bit("rst.in_ready", bus.in_ready, 1'b1);
        check_bit("rst.out_valid", bus.out_valid, 1'b0);
        check_bit("rst.stall", bus.stall, 1'b0);
        check_bit("rst.encoder_start", bus.encoder_start, 1'b0);
        check_bit("rst.err_timeout", bus.err_timeout, 1'b0);
        check_word("rst.spec_cnt", 32'(bus.spec_cnt), 32'h0);
        check_word("rst.stage_clr", 32'(bus.stage_clr), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();

        // Eight normal ops back to back: results in cycles 5..12
        for (int j = 0; j < 15; j++) begin
            clear_inputs();
            bus.in_valid    = (j < 8);
            bus.pipe_result = 32'hA000_0000 + 32'(j);
            @(negedge clk);
            check_bit($sformatf("norm.in_ready@%0d", j), bus.in_ready, 1'b1);
            check_bit($sformatf("norm.out_valid@%0d", j), bus.out_valid, (j >= 5 && j < 13));
            if (j >= 5 && j < 13)
                check_word($sformatf("norm.out_result@%0d", j), bus.out_result,
                           32'hA000_0000 + 32'(j));
            next_cycle();
        end

        // Operand NaR, done at k=2: start in cycle 6, result in cycle 10
        special_op("nar_a", 1'b0, 1'b1, 1'b0, 1'b0, 2, NAR);
        // Exponent underflow to zero, done at k=0
        special_op("exp_zero", 1'b0, 1'b0, 1'b1, 1'b0, 0, 32'h0);
        // Exponent zero and NaR together: NaR wins
        special_op("exp_both", 1'b0, 1'b0, 1'b1, 1'b1, 0, NAR);

        // Normal, special, normal; an op offered during the stall is dropped
        for (int j = 0; j < 17; j++) begin
            clear_inputs();
            bus.pipe_result = 32'hC000_0000 + 32'(j);
            if (j <= 2) bus.in_valid = 1'b1;
            if (j == 1) bus.nar_b = 1'b1;
            if (j == 7) bus.in_valid = 1'b1;
            if (j == 9) bus.encode_done = 1'b1;
            @(negedge clk);
            check_bit($sformatf("mix.out_valid@%0d", j), bus.out_valid,
                      (j == 5 || j == 10 || j == 11));
            check_bit($sformatf("mix.in_ready@%0d", j), bus.in_ready, !(j >= 6 && j <= 9));
            if (j == 5 || j == 11)
                check_word($sformatf("mix.out_result@%0d", j), bus.out_result,
                           32'hC000_0000 + 32'(j));
            if (j == 10)
                check_word("mix.out_result@10", bus.out_result, NAR);
            if (j == 7)
                check_word("mix.stage_clr@7", 32'(bus.stage_clr), 32'h10);
            if (j == 11) begin
                exp_spec++;
                check_word("mix.spec_cnt", 32'(bus.spec_cnt), 32'(exp_spec));
            end
            next_cycle();
        end

        // Encoder never answers: zero op aborts to NaR after 15 WAIT cycles
        check_bit("tmo.err_before", bus.err_timeout, 1'b0);
        special_op("tmo", 1'b1, 1'b0, 1'b0, 1'b0, -1, NAR);
        check_bit("tmo.err_set", bus.err_timeout, 1'b1);
        for (int j = 0; j < 100; j++) next_cycle();
        check_bit("tmo.err_sticky", bus.err_timeout, 1'b1);

        // Reset during WAIT with a normal op queued behind the special one
        for (int j = 0; j < 8; j++) begin
            clear_inputs();
            if (j <= 1) bus.in_valid = 1'b1;
            if (j == 0) bus.zero_b = 1'b1;
            @(negedge clk);
            if (j == 6) check_bit("rst_mid.start@6", bus.encoder_start, 1'b1);
            if (j == 7) check_bit("rst_mid.stall@7", bus.stall, 1'b1);
            next_cycle();
        end
        rst_n = 1'b0;
        #1;
        check_bit("rst_mid.stall", bus.stall, 1'b0);
        check_bit("rst_mid.encoder_start", bus.encoder_start, 1'b0);
        check_bit("rst_mid.in_ready", bus.in_ready, 1'b1);
        check_bit("rst_mid.out_valid", bus.out_valid, 1'b0);
        check_bit("rst_mid.err_timeout", bus.err_timeout, 1'b0);
        check_word("rst_mid.spec_cnt", 32'(bus.spec_cnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        for (int j = 0; j < 10; j++) begin
            clear_inputs();
            bus.in_valid    = (j == 0);
            bus.pipe_result = 32'hE000_0000 + 32'(j);
            @(negedge clk);
            check_bit($sformatf("post.out_valid@%0d", j), bus.out_valid, (j == 5));
            if (j == 5)
                check_word("post.out_result", bus.out_result, 32'hE000_0005);
            next_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
